// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer, refclk domain.
// Pulses the PLL reset, waits for a debounced lock within a bounded number of
// attempts, then releases the downstream reset. Loss of lock in RUN restarts
// the sequence. FAIL is terminal until rst.
// Optional feature macro: PLL_SEQ_LOSS_COUNT_EN (saturating lock-loss counter).
`timescale 1ns/1ps
module pll_reset_sequencer #(
   parameter int unsigned RST_PULSE_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRIES         = 3,
   parameter int unsigned SYNC_STAGES         = 2
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
   output logic [3:0] retry_count,
   output logic [7:0] lock_loss_count
);

   localparam int unsigned MaxAb  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int unsigned MaxCyc = (MaxAb > LOCK_STABLE_CYCLES) ? MaxAb : LOCK_STABLE_CYCLES;
   localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

   localparam logic [CntW-1:0] RstLast     = CntW'(RST_PULSE_CYCLES - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [3:0]      RetryMax    = 4'(MAX_RETRIES);

   localparam logic [2:0] StResetPll = 3'd0;
   localparam logic [2:0] StWaitLock = 3'd1;
   localparam logic [2:0] StStable   = 3'd2;
   localparam logic [2:0] StRun      = 3'd3;
   localparam logic [2:0] StFail     = 3'd4;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lk;
   logic [2:0]             state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [3:0]             retry_q, retry_d;
   logic                   loss_event;

   // Lock synchroniser: the only place pll_locked is sampled.
   always_ff @(posedge refclk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign lk = sync_q[SYNC_STAGES-1];

   // Sequencer next-state, shared cycle counter and retry bookkeeping.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      retry_d    = retry_q;
      loss_event = 1'b0;
      case (state_q)
         StResetPll: begin
            if (cnt_q == RstLast) begin
               state_d = StWaitLock;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWaitLock: begin
            // Lock beats timeout when both happen in the same cycle.
            if (lk) begin
               state_d = StStable;
            end else if (cnt_q == TimeoutLast) begin
               if (retry_q == RetryMax) begin
                  state_d = StFail;
               end else begin
                  retry_d = retry_q + 4'd1;
                  state_d = StResetPll;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StStable: begin
            // A dropout while debouncing restarts the wait without costing a retry.
            if (!lk) begin
               state_d = StWaitLock;
            end else if (cnt_q == StableLast) begin
               state_d = StRun;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRun: begin
            if (!lk) begin
               state_d    = StResetPll;
               retry_d    = '0;
               loss_event = 1'b1;
            end
         end
         StFail: begin
            state_d = StFail;
         end
         default: begin
            state_d = StResetPll;
         end
      endcase
      if (state_d != state_q) begin
         cnt_d = '0;
      end
   end

   // Sequencer state registers.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q <= StResetPll;
         cnt_q   <= '0;
         retry_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      pll_rst = (state_q == StResetPll) || (state_q == StFail);
      sys_rst = (state_q != StRun);
      ready   = (state_q == StRun);
      fail    = (state_q == StFail);
   end

   assign retry_count = retry_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
   logic [7:0] loss_q, loss_d;

   // Saturating count of lock-loss events seen in RUN.
   always_comb begin
      loss_d = loss_q;
      if (loss_event && (loss_q != 8'hff)) begin
         loss_d = loss_q + 8'd1;
      end
   end

   // Lock-loss counter register.
   always_ff @(posedge refclk) begin
      if (rst) begin
         loss_q <= '0;
      end else begin
         loss_q <= loss_d;
      end
   end

   assign lock_loss_count = loss_q;
`else
   logic unused_loss_event;
   assign unused_loss_event = loss_event;
   assign lock_loss_count   = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small cycle parameters.
// Cycle numbering: cycle 0 is the first cycle with rst low; edge k ends cycle k.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

   logic       refclk;
   logic       rst;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [3:0] retry_count;
   logic [7:0] lock_loss_count;

   int n_cmp;
   int n_bad;
   int cyc;

`ifdef PLL_SEQ_LOSS_COUNT_EN
   localparam int LlcOn = 1;
`else
   localparam int LlcOn = 0;
`endif

   // {pll_rst, sys_rst, ready, fail, retry_count, lock_loss_count}
   logic [15:0] obs;
   assign obs = {pll_rst, sys_rst, ready, fail, retry_count, lock_loss_count};

   pll_reset_sequencer #(
      .RST_PULSE_CYCLES   (4),
      .LOCK_TIMEOUT_CYCLES(20),
      .LOCK_STABLE_CYCLES (8),
      .MAX_RETRIES        (2),
      .SYNC_STAGES        (2)
   ) dut (
      .refclk         (refclk),
      .rst            (rst),
      .pll_locked     (pll_locked),
      .pll_rst        (pll_rst),
      .sys_rst        (sys_rst),
      .ready          (ready),
      .fail           (fail),
      .retry_count    (retry_count),
      .lock_loss_count(lock_loss_count)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   task automatic step();
      @(posedge refclk);
      #1;
      cyc++;
   endtask

   // Leaves the bench in cycle 0 with rst low.
   task automatic do_reset();
      rst        = 1'b1;
      pll_locked = 1'b0;
      repeat (2) @(posedge refclk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      logic [15:0] exp;
      rst        = 1'b1;
      pll_locked = 1'b1;
      repeat (3) @(posedge refclk);
      #1;
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL reset_values got=%b exp=%b", obs, exp);
      end
   endtask

   task automatic test_nominal();
      logic [15:0] exp;
      do_reset();
      while (cyc <= 25) begin
         exp = {cyc <= 3, cyc < 21, cyc >= 21, 1'b0, 4'd0, 8'd0};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL nominal cyc=%0d got=%b exp=%b", cyc, obs, exp);
         end
         if (cyc == 10) pll_locked = 1'b1;
         step();
      end
   endtask

   task automatic test_never_lock();
      logic [15:0] exp;
      logic        pr;
      logic [3:0]  rc;
      do_reset();
      while (cyc <= 272) begin
         pr = (cyc <= 3) || (cyc >= 24 && cyc <= 27) || (cyc >= 48 && cyc <= 51) || (cyc >= 72);
         rc = (cyc < 24) ? 4'd0 : (cyc < 48) ? 4'd1 : 4'd2;
         exp = {pr, 1'b1, 1'b0, cyc >= 72, rc, 8'd0};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL never_lock cyc=%0d got=%b exp=%b", cyc, obs, exp);
         end
         step();
      end
   endtask

   task automatic test_unstable();
      logic [15:0] exp;
      do_reset();
      while (cyc <= 40) begin
         exp = {cyc <= 3, cyc < 36, cyc >= 36, 1'b0, 4'd0, 8'd0};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL unstable cyc=%0d got=%b exp=%b", cyc, obs, exp);
         end
         if (cyc == 10) pll_locked = 1'b1;
         if (cyc == 15) pll_locked = 1'b0;
         if (cyc == 25) pll_locked = 1'b1;
         step();
      end
   endtask

   // Lock on the second attempt so retry_count is 1 in RUN, then drop lock.
   task automatic test_loss();
      logic [15:0] exp;
      logic        pr;
      logic        rdy;
      logic [3:0]  rc;
      logic [7:0]  llc;
      do_reset();
      while (cyc <= 56) begin
         pr  = (cyc <= 3) || (cyc >= 24 && cyc <= 27) || (cyc >= 48 && cyc <= 51);
         rdy = (cyc >= 41) && (cyc <= 47);
         rc  = (cyc >= 24 && cyc < 48) ? 4'd1 : 4'd0;
         llc = (cyc >= 48) ? 8'(LlcOn) : 8'd0;
         exp = {pr, !rdy, rdy, 1'b0, rc, llc};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL loss cyc=%0d got=%b exp=%b", cyc, obs, exp);
         end
         if (cyc == 30) pll_locked = 1'b1;
         if (cyc == 45) pll_locked = 1'b0;
         step();
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] exp;
      logic        pr;
      logic        rdy;
      logic        fl;
      logic [3:0]  rc;
      // From wherever the previous test left off (lock_loss_count may be 1).
      rst = 1'b1;
      step();
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL reset_any_state got=%b exp=%b", obs, exp);
      end
      rst = 1'b0;
      cyc = 0;
      // rst during STABLE (cycle 15); lock stays high so the restart reaches RUN.
      while (cyc <= 31) begin
         pr  = (cyc <= 3) || (cyc >= 16 && cyc <= 19);
         rdy = (cyc >= 29);
         exp = {pr, !rdy, rdy, 1'b0, 4'd0, 8'd0};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_stable cyc=%0d got=%b exp=%b", cyc, obs, exp);
         end
         if (cyc == 10) pll_locked = 1'b1;
         rst = (cyc == 15);
         step();
      end
      // rst during FAIL (cycle 75).
      do_reset();
      while (cyc <= 85) begin
         pr  = (cyc <= 3) || (cyc >= 24 && cyc <= 27) || (cyc >= 48 && cyc <= 51) ||
               (cyc >= 72 && cyc <= 79);
         fl  = (cyc >= 72) && (cyc <= 75);
         rc  = (cyc < 24) ? 4'd0 : (cyc < 48) ? 4'd1 : (cyc < 76) ? 4'd2 : 4'd0;
         exp = {pr, 1'b1, 1'b0, fl, rc, 8'd0};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_fail cyc=%0d got=%b exp=%b", cyc, obs, exp);
         end
         rst = (cyc == 75);
         step();
      end
   endtask

   task automatic test_saturation();
      int  wait_cnt;
      bit  timed_out;
      logic [7:0] exp;
      do_reset();
      pll_locked = 1'b1;
      timed_out  = 1'b0;
      for (int ev = 1; ev <= 300 && !timed_out; ev++) begin
         wait_cnt = 0;
         while (!ready && wait_cnt < 60) begin
            step();
            wait_cnt++;
         end
         if (!ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sat_wait_ready ev=%0d got=%b exp=1", ev, ready);
            timed_out = 1'b1;
         end else begin
            pll_locked = 1'b0;
            wait_cnt   = 0;
            while (!sys_rst && wait_cnt < 10) begin
               step();
               wait_cnt++;
            end
            if (!sys_rst) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sat_wait_sys_rst ev=%0d got=%b exp=1", ev, sys_rst);
               timed_out = 1'b1;
            end
            pll_locked = 1'b1;
            if (ev == 1 || ev == 254 || ev == 255) begin
               exp = 8'(ev * LlcOn);
               n_cmp++;
               if (lock_loss_count !== exp) begin
                  n_bad++;
                  $display("FAIL sat_count ev=%0d got=%0d exp=%0d", ev, lock_loss_count, exp);
               end
            end
         end
      end
      exp = 8'(255 * LlcOn);
      n_cmp++;
      if (lock_loss_count !== exp) begin
         n_bad++;
         $display("FAIL sat_final got=%0d exp=%0d", lock_loss_count, exp);
      end
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      cyc        = 0;
      rst        = 1'b1;
      pll_locked = 1'b0;
      test_reset();
      test_nominal();
      test_never_lock();
      test_unstable();
      test_loss();
      test_reset_mid();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
